onehot_rr_arbiter: RTL and testbench

Round-robin arbiter that accepts up to 8 independent request lines and produces a registered one-hot grant for the downstream 8-to-3 encoder stage. It guarantees that the encoder's input is always exactly one-hot while a grant is valid, never zero-hot or multi-hot. A valid/ready handshake holds each grant stable until the consumer takes it. Fairness comes from a rotating search pointer.

---
 rtl/enc_pkg.sv | 15 +
 rtl/rr_pick.sv | 34 +++
 rtl/onehot_rr_arbiter.sv | 85 ++++++++
 tb/tb_onehot_rr_arbiter.sv | 132 +++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared types for the round-robin arbiter and the downstream 8-to-3 encoder.
package enc_pkg;

    localparam int unsigned ENC_N = 8;
    localparam int unsigned ENC_W = 3;

    typedef logic [ENC_N-1:0] onehot_t;
    typedef logic [ENC_W-1:0] code_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority pick: first set request at or above ptr, wrapping.
module rr_pick
    import enc_pkg::*;
(
    input  logic    [ENC_N-1:0] req,
    input  code_t               ptr,
    output onehot_t             pick,
    output code_t               idx,
    output logic                any
);

    localparam int unsigned DW = 2 * ENC_N;

    onehot_t         mask;
    logic [DW-1:0]   dbl;
    logic            found;

    // Upper copy is unmasked, so a miss in the masked lower half wraps to bit 0.
    always_comb begin
        mask  = ~((onehot_t'(1) << ptr) - onehot_t'(1));
        dbl   = {req, req & mask};
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < int'(DW); i++) begin
            if (!found && dbl[i]) begin
                found = 1'b1;
                idx   = ENC_W'(i);
            end
        end
        any  = |req;
        pick = any ? (onehot_t'(1) << idx) : '0;
    end

endmodule

// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant and valid/ready hold.
// Optional ONEHOT_ARB_LOCK_EN adds a lock input for multi-beat ownership.
module onehot_rr_arbiter
    import enc_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic         grant_valid,
`ifdef ONEHOT_ARB_LOCK_EN
    input  logic         lock,
`endif
    input  logic         grant_ready
);

    arb_state_t state;
    code_t      ptr;
    code_t      cur_idx;
    code_t      search_ptr_c;
    onehot_t    pick_c;
    code_t      pick_idx_c;
    logic       pick_any_c;
    logic       hold_c;

    // After a handshake the search starts one past the index just served.
    assign search_ptr_c = (state == GRANT) ? (cur_idx + 3'd1) : ptr;

`ifdef ONEHOT_ARB_LOCK_EN
    assign hold_c = lock && req[cur_idx];
`else
    assign hold_c = 1'b0;
`endif

    rr_pick u_pick (
        .req (req),
        .ptr (search_ptr_c),
        .pick(pick_c),
        .idx (pick_idx_c),
        .any (pick_any_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            ptr         <= '0;
            cur_idx     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any_c) begin
                        grant       <= pick_c;
                        cur_idx     <= pick_idx_c;
                        grant_valid <= 1'b1;
                        state       <= GRANT;
                    end
                end
                GRANT: begin
                    // Locked holder keeps the grant and the pointer stays put.
                    if (grant_ready && !hold_c) begin
                        ptr <= cur_idx + 3'd1;
                        if (pick_any_c) begin
                            grant   <= pick_c;
                            cur_idx <= pick_idx_c;
                        end else begin
                            grant       <= '0;
                            grant_valid <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    grant       <= '0;
                    grant_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Directed self-checking bench for onehot_rr_arbiter.
module tb_onehot_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] grant;
    logic       grant_valid;
    logic       grant_ready;
`ifdef ONEHOT_ARB_LOCK_EN
    logic       lock;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    onehot_rr_arbiter #(.N(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .grant      (grant),
        .grant_valid(grant_valid),
`ifdef ONEHOT_ARB_LOCK_EN
        .lock       (lock),
`endif
        .grant_ready(grant_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] exp_g;
        rst = 1'b1; req = 8'hFF; grant_ready = 1'b0;
`ifdef ONEHOT_ARB_LOCK_EN
        lock = 1'b0;
`endif
        tick(); tick();
        check("reset_grant", grant, 8'h00);
        check("reset_valid", {7'd0, grant_valid}, 8'h00);

        rst = 1'b0;
        tick();
        check("first_grant", grant, 8'h01);
        check("first_valid", {7'd0, grant_valid}, 8'h01);

        // Rotation through all requesters and wrap back to 01
        grant_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_g = 8'h01 << (k % 8);
            check($sformatf("rotate_%0d", k), grant, exp_g);
        end

        // Stall: 01 accepted, ptr=1, 0x24 picks 04, then hold
        req = 8'h24;
        tick();
        grant_ready = 1'b0;
        check("stall_pick", grant, 8'h04);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) req = 8'h00;
            tick();
            check($sformatf("stall_hold_%0d", k), grant, 8'h04);
        end
        grant_ready = 1'b1;
        tick();
        check("stall_release_grant", grant, 8'h00);
        check("stall_release_valid", {7'd0, grant_valid}, 8'h00);

        // Wrap search: ptr=3 now; take 80, accept it so ptr=0
        req = 8'h80; grant_ready = 1'b0;
        tick();
        check("wrap_take80", grant, 8'h80);
        req = 8'h81; grant_ready = 1'b1;
        tick();
        check("wrap_after80", grant, 8'h01);
        req = 8'h40;
        tick();
        check("wrap_take40", grant, 8'h40);
        req = 8'h81;
        tick();
        check("wrap_after40", grant, 8'h80);
        req = 8'h00;
        tick();
        check("wrap_idle_valid", {7'd0, grant_valid}, 8'h00);

        // Reset mid-grant: stalled 08, then reset with ready high
        req = 8'h08; grant_ready = 1'b0;
        tick();
        tick();
        check("midrst_hold", grant, 8'h08);
        rst = 1'b1; grant_ready = 1'b1;
        tick();
        check("midrst_grant", grant, 8'h00);
        check("midrst_valid", {7'd0, grant_valid}, 8'h00);
        rst = 1'b0; grant_ready = 1'b0; req = 8'h0C;
        tick();
        check("midrst_ptr0", grant, 8'h04);
        req = 8'h00; grant_ready = 1'b1;
        tick();
        check("midrst_idle_valid", {7'd0, grant_valid}, 8'h00);

`ifdef ONEHOT_ARB_LOCK_EN
        rst = 1'b1;
        tick();
        rst = 1'b0; req = 8'h11; lock = 1'b1; grant_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("lock_hold_%0d", k), grant, 8'h01);
        end
        lock = 1'b0;
        tick();
        check("lock_release", grant, 8'h10);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
